// File: rtl/axil_regbank_if.sv
// AXI4-Lite bus bundle for axil_regbank: AW/W/B/AR/R channels.
// Ports: master drives addr/data/valid/ready-for-resp; slave the rest.
interface axil_regbank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARPROT, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RVALID,
    output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARPROT, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axil_regbank.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed R/W words, SLVERR
// out of range, per-register write pulses, independent wr/rd FSMs.
// Ports: ACLK, ARESET (sync, active-high), bus (axil_regbank_if.slave),
// reg_out (flat regs), wr_pulse (1/reg); with AXIL_REGBANK_IRQ_EN
// defined also evt/irq and a pending register at word NUM_REGS.
module axil_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axil_regbank_if.slave                  bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
`ifdef AXIL_REGBANK_IRQ_EN
  ,
  input  logic                           evt,
  output logic                           irq
`endif
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = ADDR_WIDTH - LSB;
  localparam logic [IW-1:0] NREG_IDX = IW'(NUM_REGS);

  localparam logic [1:0] WR_IDLE  = 2'd0;
  localparam logic [1:0] WR_GOT_A = 2'd1;
  localparam logic [1:0] WR_GOT_D = 2'd2;
  localparam logic [1:0] WR_RESP  = 2'd3;
  localparam logic [0:0] RD_IDLE  = 1'b0;
  localparam logic [0:0] RD_RESP  = 1'b1;
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] SLVERR   = 2'b10;

  logic [1:0]            wr_st;
  logic [0:0]            rd_st;
  // Keeps every READY low in the cycle right after reset.
  logic                  live;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] aw_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [SW-1:0]         ws_q;
  logic [1:0]            bresp_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [SW-1:0]         c_strb;
  logic [IW-1:0]         c_idx;
  logic                  c_ok;
  logic                  c_pend;
  logic [IW-1:0]         ar_idx;
  logic                  ar_ok;
  logic                  ar_pend;
  logic [DATA_WIDTH-1:0] rd_word;

  assign bus.AWREADY = live &&
    (wr_st == WR_IDLE || wr_st == WR_GOT_D);
  assign bus.WREADY  = live &&
    (wr_st == WR_IDLE || wr_st == WR_GOT_A);
  assign bus.BVALID  = (wr_st == WR_RESP);
  assign bus.BRESP   = bresp_q;
  assign bus.ARREADY = live && (rd_st == RD_IDLE);
  assign bus.RVALID  = (rd_st == RD_RESP);
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;

  assign aw_hs = bus.AWVALID && bus.AWREADY;
  assign w_hs  = bus.WVALID && bus.WREADY;
  assign ar_hs = bus.ARVALID && bus.ARREADY;

  wire unused_ok = ^{bus.AWPROT, bus.ARPROT,
                     c_addr[LSB-1:0], bus.ARADDR[LSB-1:0]};

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign reg_out[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Commit picks live bus fields or the half captured earlier.
  always_comb begin
    c_addr = aw_q;
    c_data = wd_q;
    c_strb = ws_q;
    commit = 1'b0;
    unique case (1'b1)
      wr_st == WR_IDLE: begin
        commit = aw_hs && w_hs;
        c_addr = bus.AWADDR;
        c_data = bus.WDATA;
        c_strb = bus.WSTRB;
      end
      wr_st == WR_GOT_A: begin
        commit = w_hs;
        c_data = bus.WDATA;
        c_strb = bus.WSTRB;
      end
      wr_st == WR_GOT_D: begin
        commit = aw_hs;
        c_addr = bus.AWADDR;
      end
      default: ;
    endcase
  end

  assign c_idx  = c_addr[ADDR_WIDTH-1:LSB];
  assign c_ok   = (c_idx < NREG_IDX);
  assign ar_idx = bus.ARADDR[ADDR_WIDTH-1:LSB];

`ifdef AXIL_REGBANK_IRQ_EN
  logic pend;

  assign c_pend  = (c_idx == NREG_IDX);
  assign ar_pend = (ar_idx == NREG_IDX);
  assign irq     = pend;

  // Set has priority over a same-cycle clear.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pend <= 1'b0;
    end else if (evt) begin
      pend <= 1'b1;
    end else if (commit && c_pend &&
                 c_strb[0] && c_data[0]) begin
      pend <= 1'b0;
    end
  end
`else
  assign c_pend  = 1'b0;
  assign ar_pend = 1'b0;
`endif

  assign ar_ok = (ar_idx < NREG_IDX) || ar_pend;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ar_idx == IW'(k)) rd_word = regs[k];
    end
`ifdef AXIL_REGBANK_IRQ_EN
    if (ar_pend) rd_word = {{(DATA_WIDTH-1){1'b0}}, pend};
`endif
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_st    <= WR_IDLE;
      aw_q     <= '0;
      wd_q     <= '0;
      ws_q     <= '0;
      bresp_q  <= OKAY;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      unique case (wr_st)
        WR_IDLE: begin
          if (commit) begin
            wr_st <= WR_RESP;
          end else if (aw_hs) begin
            aw_q  <= bus.AWADDR;
            wr_st <= WR_GOT_A;
          end else if (w_hs) begin
            wd_q  <= bus.WDATA;
            ws_q  <= bus.WSTRB;
            wr_st <= WR_GOT_D;
          end
        end
        WR_GOT_A,
        WR_GOT_D: begin
          if (commit) wr_st <= WR_RESP;
        end
        default: begin
          if (bus.BREADY) wr_st <= WR_IDLE;
        end
      endcase
      if (commit) begin
        bresp_q <= (c_ok || c_pend) ? OKAY : SLVERR;
        for (int k = 0; k < NUM_REGS; k++) begin
          wr_pulse[k] <= c_ok && (c_idx == IW'(k)) &&
                         (|c_strb);
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= RESET_VAL;
      end
    end else if (commit && c_ok) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (c_idx == IW'(k)) begin
          for (int b = 0; b < SW; b++) begin
            if (c_strb[b]) begin
              regs[k][b*8 +: 8] <= c_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // rd_word samples regs before a same-edge commit lands.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_st   <= RD_IDLE;
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else begin
      unique case (rd_st)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_st   <= RD_RESP;
            rdata_q <= ar_ok ? rd_word : '0;
            rresp_q <= ar_ok ? OKAY : SLVERR;
          end
        end
        default: begin
          if (bus.RREADY) rd_st <= RD_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axil_regbank.sv
// Testbench for axil_regbank: table-driven write/read vectors
// plus hand sequences for stalls, same-edge access, reset, irq.
module tb_axil_regbank;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 4;
`ifdef AXIL_REGBANK_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axil_regbank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    wr_pulse;
`ifdef AXIL_REGBANK_IRQ_EN
  logic evt;
  logic irq;
`endif

  axil_regbank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)
  ) dut (
    .ACLK(clk),
    .ARESET(rst),
    .bus(bus),
    .reg_out(reg_out),
    .wr_pulse(wr_pulse)
`ifdef AXIL_REGBANK_IRQ_EN
    ,
    .evt(evt),
    .irq(irq)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic axi_write(input logic [7:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s,
                           output logic [1:0] resp,
                           output logic [3:0] pulse);
    int n;
    logic awf;
    logic wf;
    bus.AWADDR  = a;
    bus.WDATA   = d;
    bus.WSTRB   = s;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    n = 0;
    while ((bus.AWVALID || bus.WVALID) && n < 20) begin
      awf = bus.AWVALID && bus.AWREADY;
      wf  = bus.WVALID && bus.WREADY;
      @(negedge clk);
      n++;
      if (awf) bus.AWVALID = 1'b0;
      if (wf)  bus.WVALID  = 1'b0;
    end
    while (!bus.BVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    if (n >= 20) timeout("write");
    resp  = bus.BRESP;
    pulse = wr_pulse;
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a,
                          output logic [31:0] d,
                          output logic [1:0] resp);
    int n;
    logic arf;
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    n = 0;
    while (bus.ARVALID && n < 20) begin
      arf = bus.ARREADY;
      @(negedge clk);
      n++;
      if (arf) bus.ARVALID = 1'b0;
    end
    while (!bus.RVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.ARVALID = 1'b0;
    if (n >= 20) timeout("read");
    d    = bus.RDATA;
    resp = bus.RRESP;
    bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [3:0]  exp_pulse;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v [19];
    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] rd;
    logic [1:0]  oor16;
    int hold;
    int pc;

    oor16 = IRQ ? 2'b00 : 2'b10;
    v[0]  = '{1'b1, 8'h00, 32'h1, 4'hF, 32'h0, 2'b00, 4'h1};
    v[1]  = '{1'b1, 8'h04, 32'h2, 4'hF, 32'h0, 2'b00, 4'h2};
    v[2]  = '{1'b1, 8'h08, 32'h3, 4'hF, 32'h0, 2'b00, 4'h4};
    v[3]  = '{1'b1, 8'h0C, 32'h4, 4'hF, 32'h0, 2'b00, 4'h8};
    v[4]  = '{1'b0, 8'h00, 32'h0, 4'h0, 32'h1, 2'b00, 4'h0};
    v[5]  = '{1'b0, 8'h04, 32'h0, 4'h0, 32'h2, 2'b00, 4'h0};
    v[6]  = '{1'b0, 8'h08, 32'h0, 4'h0, 32'h3, 2'b00, 4'h0};
    v[7]  = '{1'b0, 8'h0C, 32'h0, 4'h0, 32'h4, 2'b00, 4'h0};
    v[8]  = '{1'b1, 8'h00, 32'hAABBCCDD, 4'hF,
              32'h0, 2'b00, 4'h1};
    v[9]  = '{1'b1, 8'h00, 32'h11223344, 4'h5,
              32'h0, 2'b00, 4'h1};
    v[10] = '{1'b0, 8'h00, 32'h0, 4'h0,
              32'hAA22CC44, 2'b00, 4'h0};
    v[11] = '{1'b1, 8'h04, 32'hFFFFFFFF, 4'h0,
              32'h0, 2'b00, 4'h0};
    v[12] = '{1'b0, 8'h05, 32'h0, 4'h0, 32'h2, 2'b00, 4'h0};
    v[13] = '{1'b1, 8'h40, 32'hDEAD, 4'hF, 32'h0, 2'b10, 4'h0};
    v[14] = '{1'b0, 8'h40, 32'h0, 4'h0, 32'h0, 2'b10, 4'h0};
    v[15] = '{1'b0, 8'hFF, 32'h0, 4'h0, 32'h0, 2'b10, 4'h0};
    v[16] = '{1'b1, 8'h10, 32'h0, 4'hF, 32'h0, oor16, 4'h0};
    v[17] = '{1'b0, 8'h10, 32'h0, 4'h0, 32'h0, oor16, 4'h0};
    v[18] = '{1'b0, 8'h0F, 32'h0, 4'h0, 32'h4, 2'b00, 4'h0};

    rst = 1'b1;
    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
`ifdef AXIL_REGBANK_IRQ_EN
    evt = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_awready", bus.AWREADY, 0);
    check("rst_wready", bus.WREADY, 0);
    check("rst_arready", bus.ARREADY, 0);
    check("rst_bvalid", bus.BVALID, 0);
    check("rst_rvalid", bus.RVALID, 0);
    check("rst_resp", {bus.BRESP, bus.RRESP}, 0);
    check("rst_rdata", bus.RDATA, 0);
    check("rst_regs", reg_out, 0);
    check("rst_pulse", wr_pulse, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready",
          {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);

    for (int i = 0; i < 19; i++) begin
      if (v[i].wr) begin
        axi_write(v[i].addr, v[i].data, v[i].strb,
                  resp, pulse);
        check($sformatf("v%0d_bresp", i), resp, v[i].exp_resp);
        check($sformatf("v%0d_pulse", i), pulse,
              v[i].exp_pulse);
      end else begin
        axi_read(v[i].addr, rd, resp);
        check($sformatf("v%0d_rdata", i), rd, v[i].exp_data);
        check($sformatf("v%0d_rresp", i), resp,
              v[i].exp_resp);
      end
    end
    check("reg_out_flat", reg_out,
          {32'h4, 32'h3, 32'h2, 32'hAA22CC44});

    // AW three cycles ahead of W, then B stalled five cycles.
    bus.AWADDR  = 8'h08;
    bus.AWVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0;
    check("gota_awready", bus.AWREADY, 0);
    check("gota_wready", bus.WREADY, 1);
    @(negedge clk);
    @(negedge clk);
    check("gota_hold", {bus.AWREADY, bus.BVALID}, 0);
    bus.WDATA  = 32'h77;
    bus.WSTRB  = 4'hF;
    bus.WVALID = 1'b1;
    @(negedge clk);
    bus.WVALID = 1'b0;
    check("stall_bvalid", bus.BVALID, 1);
    check("stall_bresp", bus.BRESP, 0);
    check("stall_pulse", wr_pulse, 4'h4);
    hold = 0;
    pc = 1;
    repeat (5) begin
      @(negedge clk);
      if (bus.BVALID && bus.BRESP == 2'b00 &&
          !bus.AWREADY && !bus.WREADY) hold++;
      if (wr_pulse[2]) pc++;
    end
    check("stall_hold", hold, 5);
    check("stall_pulse_count", pc, 1);
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    check("stall_release", bus.BVALID, 0);
    check("stall_reg2", reg_out[64 +: 32], 32'h77);

    // Same-edge write and read of reg1 returns old value.
    bus.AWADDR = 8'h04; bus.WDATA = 32'h5; bus.WSTRB = 4'hF;
    bus.ARADDR = 8'h04;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    check("same_edge_valid", {bus.BVALID, bus.RVALID}, 2'b11);
    check("same_edge_rdata", bus.RDATA, 32'h2);
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    axi_read(8'h04, rd, resp);
    check("same_edge_after", rd, 32'h5);

    // Reset in the middle of a write and a read.
    bus.AWADDR = 8'h00; bus.ARADDR = 8'h00;
    bus.AWVALID = 1'b1; bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
    check("mid_rvalid", bus.RVALID, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", {bus.BVALID, bus.RVALID}, 0);
    @(negedge clk);
    check("mid_rst_idle", {bus.AWREADY, bus.WREADY}, 2'b11);
    check("mid_rst_regs", reg_out, 0);

`ifdef AXIL_REGBANK_IRQ_EN
    evt = 1'b1;
    @(negedge clk);
    evt = 1'b0;
    check("irq_set", irq, 1);
    axi_read(8'h10, rd, resp);
    check("irq_read", {resp, rd}, {2'b00, 32'h1});
    evt = 1'b1;
    axi_write(8'h10, 32'h1, 4'hF, resp, pulse);
    evt = 1'b0;
    check("irq_set_wins", irq, 1);
    check("irq_wr_pulse", pulse, 0);
    axi_write(8'h10, 32'h1, 4'hF, resp, pulse);
    check("irq_clear", irq, 0);
    check("irq_clear_resp", resp, 0);
    axi_read(8'h10, rd, resp);
    check("irq_read_clear", rd, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
